// File: rtl/div_issue_if.sv
// Request/response handshake bundle between the EXU dispatch and
// the divide issue controller.
interface div_issue_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Execute-stage initiator for the multi-cycle divider: operand
// extension, local div-by-zero/overflow resolution, issue and result return.
module div_issue_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    div_issue_if.slave      bus,
    output logic            o_busy,
    output logic            o_div_valid,
    output logic            o_div_sign,
    output logic [XLEN-1:0] o_div_x,
    output logic [XLEN-1:0] o_div_y,
    input  logic            i_div_data_ok,
    input  logic [XLEN-1:0] i_div_data,
    input  logic [XLEN-1:0] i_rem_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic            r_word;
    logic            r_rem;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_data;
    logic            r_busy;
    logic            r_div_valid;
    logic            r_div_sign;
    logic [XLEN-1:0] r_div_x;
    logic [XLEN-1:0] r_div_y;

    logic            w_uns;
    logic            w_rem;
    logic            w_word;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_dz;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic [XLEN-1:0] w_div_res;
    logic            w_accept;

    function automatic logic [XLEN-1:0] fmt_w(
        input logic [XLEN-1:0] v,
        input logic            w
    );
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [XLEN-1:0] ext_op(
        input logic [XLEN-1:0] v,
        input logic            w,
        input logic            u
    );
        if (!w)
            return v;
        return {{(XLEN-32){v[31] & ~u}}, v[31:0]};
    endfunction

    assign w_uns  = bus.req_op[0];
    assign w_rem  = bus.req_op[1];
    assign w_word = bus.req_op[2];
    assign w_a    = ext_op(bus.req_a, w_word, w_uns);
    assign w_b    = ext_op(bus.req_b, w_word, w_uns);
    assign w_dz   = (w_b == '0);

    // Signed overflow: most-negative dividend by -1, at the op's width.
    always_comb begin
        w_ovf = 1'b0;
        if (!w_uns) begin
            if (w_word)
                w_ovf = (bus.req_a[31:0] == 32'h8000_0000) &&
                        (bus.req_b[31:0] == 32'hFFFF_FFFF);
            else
                w_ovf = (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (bus.req_b == '1);
        end
    end

    // Overflow quotient equals the extended dividend in both widths.
    assign w_fast     = w_dz | w_ovf;
    assign w_fast_res = fmt_w(w_rem ? (w_dz ? w_a : '0)
                                    : (w_dz ? '1  : w_a), w_word);
    assign w_div_res  = fmt_w(r_rem ? i_rem_data : i_div_data, r_word);
    assign w_accept   = bus.req_valid & r_req_ready & ~i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_word       <= 1'b0;
            r_rem        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_busy       <= 1'b0;
            r_div_valid  <= 1'b0;
            r_div_sign   <= 1'b0;
            r_div_x      <= '0;
            r_div_y      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_word      <= w_word;
                        r_rem       <= w_rem;
                        r_div_x     <= w_a;
                        r_div_y     <= w_b;
                        r_div_sign  <= ~w_uns;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_fast) begin
                            r_resp_data  <= w_fast_res;
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_div_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_div_valid <= 1'b0;
                    r_state     <= i_flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (i_flush) begin
                        if (i_div_data_ok) begin
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (i_div_data_ok) begin
                        r_resp_data  <= w_div_res;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_flush || bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (i_div_data_ok) begin
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_div_valid  <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign o_busy         = r_busy;
    assign o_div_valid    = r_div_valid;
    assign o_div_sign     = r_div_sign;
    assign o_div_x        = r_div_x;
    assign o_div_y        = r_div_y;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: directed ops push expected
// results, a negedge monitor pops and compares on each response.
module tb_div_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        busy;
    logic        div_valid;
    logic        div_sign;
    logic [63:0] div_x;
    logic [63:0] div_y;
    logic        div_data_ok;
    logic [63:0] div_data;
    logic [63:0] rem_data;

    div_issue_if #(.XLEN(64)) bus ();

    div_issue_ctrl #(.XLEN(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (flush),
        .bus           (bus.slave),
        .o_busy        (busy),
        .o_div_valid   (div_valid),
        .o_div_sign    (div_sign),
        .o_div_x       (div_x),
        .o_div_y       (div_y),
        .i_div_data_ok (div_data_ok),
        .i_div_data    (div_data),
        .i_rem_data    (rem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          n_pulse = 0;
    int          n_rv    = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (div_valid)
            n_pulse++;
        if (bus.resp_valid)
            n_rv++;
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_resp", {63'b0, bus.resp_valid}, 64'd0);
            else
                chk("resp_data", bus.resp_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({nm, "_rdy"}, {63'b0, bus.req_ready}, 64'd1);
    endtask

    task automatic accept(input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic pulse_ok(input logic [63:0] q, input logic [63:0] r);
        div_data_ok = 1'b1;
        div_data    = q;
        rem_data    = r;
        @(posedge clk);
        #1;
        div_data_ok = 1'b0;
    endtask

    task automatic do_op(input string nm, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input bit fast, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] dq,
                         input logic [63:0] dr, input logic [63:0] ex,
                         input int hold);
        int   p0;
        logic sgn;
        p0  = n_pulse;
        sgn = ~op[0];
        wait_ready(nm);
        exp_q.push_back(ex);
        accept(op, a, b);
        if (fast) begin
            chk({nm, "_lat1"}, {63'b0, bus.resp_valid}, 64'd1);
        end else begin
            chk({nm, "_dv"}, {63'b0, div_valid}, 64'd1);
            chk({nm, "_sign"}, {63'b0, div_sign}, {63'b0, sgn});
            chk({nm, "_x"}, div_x, x);
            chk({nm, "_y"}, div_y, y);
            repeat (3) @(posedge clk);
            #1;
            chk({nm, "_xhold"}, div_x, x);
            pulse_ok(dq, dr);
        end
        repeat (hold) begin
            chk({nm, "_hold"}, {63'b0, bus.resp_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        chk({nm, "_v"}, {63'b0, bus.resp_valid}, 64'd1);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk({nm, "_pulses"}, 64'(n_pulse - p0), fast ? 64'd0 : 64'd1);
    endtask

    initial begin
        int p0;
        int rv0;
        rst            = 1'b1;
        flush          = 1'b0;
        div_data_ok    = 1'b0;
        div_data       = '0;
        rem_data       = '0;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        #2;
        chk("rst_req_ready", {63'b0, bus.req_ready}, 64'd1);
        chk("rst_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        chk("rst_resp_data", bus.resp_data, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_div_valid", {63'b0, div_valid}, 64'd0);
        chk("rst_div_x", div_x, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // flush in IDLE blocks the accept
        flush = 1'b1;
        accept(3'b000, 64'd9, 64'd3);
        flush = 1'b0;
        chk("fidle_ready", {63'b0, bus.req_ready}, 64'd1);
        chk("fidle_busy", {63'b0, busy}, 64'd0);

        do_op("div", 3'b000, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 1'b0,
              64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA,
              64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        do_op("remu", 3'b011, 64'd100, 64'd7, 1'b0, 64'd100, 64'd7,
              64'd14, 64'd2, 64'd2, 3);
        do_op("divw", 3'b100, 64'h1_FFFF_FFF0, 64'd4, 1'b0,
              64'hFFFF_FFFF_FFFF_FFF0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC,
              64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        do_op("divuw", 3'b101, 64'hABCD_0000_FFFF_FFFE, 64'h7_0000_0001,
              1'b0, 64'h0000_0000_FFFF_FFFE, 64'd1,
              64'h0000_0000_FFFF_FFFE, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1);

        do_op("divu_z", 3'b001, 64'd5, 64'd0, 1'b1, '0, '0, '0, '0,
              64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op("rem_z", 3'b010, 64'd5, 64'd0, 1'b1, '0, '0, '0, '0,
              64'd5, 1);
        do_op("remuw_z", 3'b111, 64'h0000_0000_8000_0001, 64'h5_0000_0000,
              1'b1, '0, '0, '0, '0, 64'hFFFF_FFFF_8000_0001, 0);
        do_op("div_ovf", 3'b000, 64'h8000_0000_0000_0000, '1, 1'b1,
              '0, '0, '0, '0, 64'h8000_0000_0000_0000, 0);
        do_op("remw_ovf", 3'b110, 64'h1234_5678_8000_0000,
              64'h0000_0000_FFFF_FFFF, 1'b1, '0, '0, '0, '0, 64'd0, 0);
        do_op("divw_ovf", 3'b100, 64'h0000_0000_8000_0000,
              64'h0000_0000_FFFF_FFFF, 1'b1, '0, '0, '0, '0,
              64'hFFFF_FFFF_8000_0000, 0);

        // flush in DONE drops the response
        wait_ready("fdone");
        accept(3'b001, 64'd5, 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fdone_valid", {63'b0, bus.resp_valid}, 64'd0);
        chk("fdone_ready", {63'b0, bus.req_ready}, 64'd1);

        // flush three cycles after issue, then drain
        p0  = n_pulse;
        rv0 = n_rv;
        wait_ready("fwait");
        accept(3'b000, 64'd10, 64'd2);
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("drain_busy0", {63'b0, busy}, 64'd1);
        chk("drain_ready0", {63'b0, bus.req_ready}, 64'd0);
        pulse_ok(64'd0, 64'd0);
        // extra data_ok-free wait would hang; confirm drain released
        chk("drain_ready1", {63'b0, bus.req_ready}, 64'd1);
        chk("drain_busy1", {63'b0, busy}, 64'd0);
        chk("drain_norv", 64'(n_rv - rv0), 64'd0);
        chk("drain_pulses", 64'(n_pulse - p0), 64'd1);

        // flush and completion in the same WAIT cycle
        rv0 = n_rv;
        wait_ready("fok");
        accept(3'b000, 64'd12, 64'd4);
        @(posedge clk);
        #1;
        flush = 1'b1;
        pulse_ok(64'd3, 64'd0);
        flush = 1'b0;
        chk("fok_ready", {63'b0, bus.req_ready}, 64'd1);
        chk("fok_busy", {63'b0, busy}, 64'd0);
        chk("fok_norv", 64'(n_rv - rv0), 64'd0);

        // asynchronous reset mid-WAIT
        wait_ready("rwait");
        accept(3'b000, 64'd9, 64'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("rwait_busy", {63'b0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_req_ready", {63'b0, bus.req_ready}, 64'd1);
        chk("arst_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        chk("arst_resp_data", bus.resp_data, 64'd0);
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_div_sign", {63'b0, div_sign}, 64'd0);
        chk("arst_div_x", div_x, 64'd0);
        chk("arst_div_y", div_y, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("q_left", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Execute-stage initiator for the multi-cycle 64-bit divider; sits between the EXU op dispatch and the divider unit.
- Accepts one RV64M divide-class op per request.
- Extends W-form operands and resolves divide-by-zero and signed overflow locally, without issuing to the divider.
- Otherwise issues a single div_valid pulse, waits for div_data_ok, selects quotient or remainder, formats W results and returns them with a valid/ready handshake.

Parameters:
- XLEN, 64, datapath width (the divider interface is fixed at 64).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush; aborts the op in flight
- req_valid  in  1  op request
- req_ready  out  1  controller can accept an op
- req_op  in  3  bit0 = unsigned, bit1 = remainder, bit2 = word (W form)
- req_a  in  64  rs1 (dividend)
- req_b  in  64  rs2 (divisor)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_data  out  64  final rd value
- busy  out  1  high in any state other than IDLE; drives the EXU stall
- div_valid  out  1  start pulse to the divider
- div_sign  out  1  1 = signed divide
- div_x  out  64  extended dividend
- div_y  out  64  extended divisor
- div_data_ok  in  1  divider completion
- div_data  in  64  quotient
- rem_data  in  64  remainder

Behaviour:
- Reset values: state = IDLE; req_ready = 1; resp_valid = 0; resp_data = 0; busy = 0; div_valid = 0; div_sign = 0; div_x = 0; div_y = 0. All internal registers are cleared.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- req_ready = (state == IDLE). An op is accepted on the cycle where req_valid && req_ready.
- Operand extension on accept:
  - word && signed: sign-extend bits [31:0].
  - word && unsigned: zero-extend bits [31:0].
  - otherwise: pass through.
  - The extended operands and op bits are latched.
- Fast path, decided on the accept cycle:
  - Divide-by-zero: extended b == 0. Quotient = all ones. Remainder = extended a.
  - Signed overflow, non-word: a = 0x8000_0000_0000_0000 and b = all ones. Quotient = a. Remainder = 0.
  - Signed overflow, word: a[31:0] = 0x8000_0000 and b[31:0] = 0xFFFF_FFFF. Quotient = sign-extended 0x8000_0000. Remainder = 0.
  - Either case goes IDLE -> DONE, with resp_valid rising on the next cycle (latency 1). The divider is not touched.
- Normal path:
  - IDLE -> ISSUE. div_valid = 1 for exactly one cycle in ISSUE, with div_sign = ~op[0] and div_x/div_y = extended operands held stable.
  - ISSUE -> WAIT.
  - In WAIT, on div_data_ok: select rem_data if op[1], else div_data; latch into resp_data; go to DONE.
  - div_data_ok outside WAIT/DRAIN is ignored.
- W result formatting: resp_data = sign-extended bit 31 of the selected value. This applies to both signed and unsigned W forms.
- DONE: resp_valid = 1 and resp_data held stable until resp_ready. On resp_valid && resp_ready, go to IDLE; req_ready rises the next cycle, so there is no same-cycle back-to-back accept.
- Flush:
  - In ISSUE or WAIT: go to DRAIN and discard the result; stay in DRAIN until div_data_ok, then go to IDLE.
  - If div_data_ok and flush are both high in WAIT: go to IDLE with no result.
  - In DONE: drop resp_valid and go to IDLE.
  - In IDLE: block any accept that cycle.
  - resp_valid is never asserted for a flushed op.
- busy = (state != IDLE). DRAIN counts as busy, so the next op waits for the divider to become free.
- Asynchronous rst at any point forces the reset values immediately. The divider is assumed to be reset by the same rst.

Test Plan:
- Signed normal: DIV a = -20, b = 3 (op 000) -> one div_valid pulse with div_sign = 1; after div_data_ok, resp_data = 0xFFFF_FFFF_FFFF_FFFA (-6).
- Unsigned remainder: REMU a = 100, b = 7 (op 011) -> resp_data = 2; div_sign = 0; resp_valid held through 3 cycles of resp_ready = 0.
- Word divide: DIVW a = 0x1_FFFF_FFF0, b = 0x4 (op 100) -> div_x = 0xFFFF_FFFF_FFFF_FFF0; resp_data = 0xFFFF_FFFF_FFFF_FFFC.
- Divide-by-zero: DIVU a = 5, b = 0 -> no div_valid; resp_valid 1 cycle after accept with resp_data = all ones. REM a = 5, b = 0 -> resp_data = 5.
- Overflow: DIV a = 0x8000_0000_0000_0000, b = -1 -> resp_data = 0x8000_0000_0000_0000. REMW with the word-overflow operands -> resp_data = 0. No div_valid in either case.
- Flush in WAIT: assert flush 3 cycles after issue -> DRAIN, busy stays 1 until div_data_ok, no resp_valid, req_ready returns 1. Assert rst mid-WAIT -> all outputs return to their reset values immediately.
